// File: rtl/fnd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fnd_pkg                                                    |
// | Purpose  : Shared types, constants and BCD helper for the FND path.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package fnd_pkg;

  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam logic [3:0]  BCD_DOT   = 4'hE;
  localparam logic [13:0] MAX_VALUE = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Digit 0 is the ones digit.
  typedef logic [3:0][3:0] bcd4_t;

  function automatic bcd4_t dabble_adjust(input bcd4_t d);
    bcd4_t r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (d[i] >= 4'd5) r[i] = d[i] + 4'd3;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : bin2bcd_seq                                                |
// | Purpose  : Handshaked, saturating 14-bit to 4-digit double-dabble.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [13:0] in_value,
  output logic        in_ready,
  output bcd4_t       bcd_out,
  output logic        done
);

  conv_state_t r_state;
  logic [13:0] r_bin;
  bcd4_t       r_bcd;
  bcd4_t       r_out;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_done;

  bcd4_t       w_adj;
  logic [29:0] w_shift;

  assign w_adj   = dabble_adjust(r_bcd);
  assign w_shift = {w_adj, r_bin} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Ready re-asserts one edge after the done pulse so it lines up with the display update.
          if (r_done) begin
            r_ready <= 1'b1;
          end else if (in_valid && r_ready) begin
            r_bin   <= (in_value > MAX_VALUE) ? MAX_VALUE : in_value;
            r_bcd   <= '0;
            r_cnt   <= 4'd13;
            r_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_shift[29:14];
          r_bin <= w_shift[13:0];
          if (r_cnt == 4'd0) r_state <= COMMIT;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        COMMIT: begin
          r_out   <= r_bcd;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = r_ready;
  assign bcd_out  = r_out;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fnd_scan_ctrl                                              |
// | Purpose  : Value-to-BCD conversion and 4-digit FND scan multiplexing. |
// |            Define FND_LZ_BLANK_EN to blank leading zero digits.       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        value_valid,
  input  logic [13:0] value,
  output logic        value_ready,
  output logic [3:0]  fnd_comm,
  output logic [3:0]  bcd_data
);

  localparam int c_div = CLK_FREQ / SCAN_HZ;
  localparam int c_pw  = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_pw-1:0] c_pre_last = c_pw'(c_div - 1);

  logic [c_pw-1:0] r_pre;
  logic [1:0]      r_sel;
  bcd4_t           r_disp;
  logic [3:0]      r_comm;
  logic [3:0]      r_bcd;

  logic            w_tick;
  logic [1:0]      w_sel_next;
  bcd4_t           w_conv;
  bcd4_t           w_commit;
  logic            w_done;

  bin2bcd_seq u_conv (
    .clk      (clk),
    .reset    (reset),
    .in_valid (value_valid),
    .in_value (value),
    .in_ready (value_ready),
    .bcd_out  (w_conv),
    .done     (w_done)
  );

  assign w_tick     = (r_pre == c_pre_last);
  assign w_sel_next = w_tick ? r_sel + 2'd1 : r_sel;

`ifdef FND_LZ_BLANK_EN
  logic w_lead;
  always_comb begin
    w_commit = w_conv;
    w_lead   = 1'b1;
    // Digit 0 is never blanked so a zero value still shows "0".
    for (int i = 3; i >= 1; i--) begin
      if (w_lead && (w_conv[i] == 4'd0)) w_commit[i] = BCD_BLANK;
      else                               w_lead      = 1'b0;
    end
  end
`else
  always_comb begin
    w_commit = w_conv;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre  <= '0;
      r_sel  <= 2'd0;
      r_disp <= {4{BCD_BLANK}};
      r_comm <= 4'b1110;
      r_bcd  <= BCD_BLANK;
    end else begin
      r_pre  <= w_tick ? '0 : r_pre + 1'b1;
      r_sel  <= w_sel_next;
      if (w_done) r_disp <= w_commit;
      r_comm <= ~(4'b0001 << w_sel_next);
      r_bcd  <= r_disp[w_sel_next];
    end
  end

  assign fnd_comm = r_comm;
  assign bcd_data = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_fnd_scan_ctrl                                           |
// | Purpose  : Directed self-checking bench for fnd_scan_ctrl.            |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        value_valid;
  logic [13:0] value;
  logic        value_ready;
  logic [3:0]  fnd_comm;
  logic [3:0]  bcd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .fnd_comm    (fnd_comm),
    .bcd_data    (bcd_data)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Collect one full scan: d[4*k +: 4] is the code shown while digit k is selected.
  task automatic capture(input string tag, input logic [15:0] exp);
    logic [15:0] d;
    logic [3:0]  seen;
    d    = 16'hxxxx;
    seen = 4'd0;
    for (int n = 0; n < 80 && seen != 4'hF; n++) begin
      @(negedge clk);
      case (fnd_comm)
        4'b1110: begin d[3:0]   = bcd_data; seen[0] = 1'b1; end
        4'b1101: begin d[7:4]   = bcd_data; seen[1] = 1'b1; end
        4'b1011: begin d[11:8]  = bcd_data; seen[2] = 1'b1; end
        4'b0111: begin d[15:12] = bcd_data; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    check({tag, "_slots"}, {12'd0, seen}, 16'h000F);
    check(tag, d, exp);
  endtask

  task automatic wait_ready(input string tag);
    for (int n = 0; n < 40 && value_ready !== 1'b1; n++) @(negedge clk);
    check(tag, {15'd0, value_ready}, 16'd1);
  endtask

  task automatic convert(input logic [13:0] v, input string tag, input logic [15:0] exp);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_ready({tag, "_ready"});
    repeat (2) @(negedge clk);
    capture(tag, exp);
  endtask

  logic [3:0] seq [4];
  logic [3:0] prev;

  initial begin
    reset       = 1'b1;
    value_valid = 1'b0;
    value       = '0;
    repeat (3) @(negedge clk);
    check("rst_comm",  {12'd0, fnd_comm}, 16'h000E);
    check("rst_bcd",   {12'd0, bcd_data}, 16'h000F);
    check("rst_ready", {15'd0, value_ready}, 16'd1);
    reset = 1'b0;

    // Scan order and 10-cycle slot spacing.
    for (int n = 0; n < 20 && fnd_comm === 4'b1110; n++) @(negedge clk);
    check("scan_first", {12'd0, fnd_comm}, 16'h000D);
    seq[0] = 4'b1011; seq[1] = 4'b0111; seq[2] = 4'b1110; seq[3] = 4'b1101;
    prev = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      repeat (9) @(negedge clk);
      check("scan_hold", {12'd0, fnd_comm}, {12'd0, prev});
      @(negedge clk);
      check("scan_step", {12'd0, fnd_comm}, {12'd0, seq[k]});
      prev = seq[k];
    end
    capture("blank_display", 16'hFFFF);

    // 1234 with exact ready latency.
    @(negedge clk);
    value       = 14'd1234;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    check("busy_n0", {15'd0, value_ready}, 16'd0);
    repeat (15) @(negedge clk);
    check("busy_n15", {15'd0, value_ready}, 16'd0);
    @(negedge clk);
    check("ready_n16", {15'd0, value_ready}, 16'd1);
    repeat (2) @(negedge clk);
    capture("conv_1234", 16'h1234);

    // Saturation with an ignored second request while busy.
    @(negedge clk);
    value       = 14'd12000;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (2) @(negedge clk);
    value       = 14'd5678;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    check("busy_ignore", {15'd0, value_ready}, 16'd0);
    wait_ready("sat_ready");
    repeat (2) @(negedge clk);
    capture("sat_12000", 16'h9999);
    check("no_requeue", {15'd0, value_ready}, 16'd1);

    convert(14'd10000, "sat_10000", 16'h9999);
    convert(14'd9998,  "conv_9998", 16'h9998);
`ifdef FND_LZ_BLANK_EN
    convert(14'd7, "lz_7", 16'hFFF7);
    convert(14'd0, "lz_0", 16'hFFF0);
`else
    convert(14'd7, "lz_7", 16'h0007);
    convert(14'd0, "lz_0", 16'h0000);
`endif

    // Abort mid-conversion with an asynchronous reset.
    @(negedge clk);
    value       = 14'd1234;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_comm",  {12'd0, fnd_comm}, 16'h000E);
    check("abort_bcd",   {12'd0, bcd_data}, 16'h000F);
    check("abort_ready", {15'd0, value_ready}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    capture("abort_blank", 16'hFFFF);
`ifdef FND_LZ_BLANK_EN
    convert(14'd42, "conv_42", 16'hFF42);
`else
    convert(14'd42, "conv_42", 16'h0042);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
